fnd_scan_monitor: RTL and testbench
===================================

Name: fnd_scan_monitor

Overview:
- Receive-side counterpart of the FND display controller: samples the multiplexed 7-segment scan bus (fndCom/fndFont) and rebuilds the displayed 14-bit decimal value.
- Decodes each segment pattern back to a digit, assembles one frame per full 4-position sweep, and emits the value with a one-cycle valid strobe.
- Used for on-chip loopback self-check of the display path and as a bench-side monitor.

Parameters:
- STABLE_CYCLES, 16, consecutive identical samples of (fndCom, fndFont) required before a position is captured.
- TIMEOUT_CYCLES, 400_000, cycles without a capture before a partial frame is discarded.

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  asynchronous, active-high reset
- fndCom  input  4  scan common lines, active-low one-hot
- fndFont  input  8  segment lines, active-low; bit7 = DP
- digit  output  14  last complete decoded value, 0..9999
- digit_valid  output  1  one-cycle pulse when digit is updated
- frame_err  output  1  one-cycle pulse on an invalid pattern or a non-decimal digit

Behaviour:
- Reset values: digit=0, digit_valid=0, frame_err=0. Slot registers, seen[3:0], stability counter and timeout counter all clear to 0. State is IDLE.
- Input sampling: fndCom and fndFont pass through a 2-flop synchronizer. All logic below acts on the synchronized copies.
- Position decode: 1110->0, 1101->1, 1011->2, 0111->3. Any other pattern (1111, multiple lows) is blanking: no capture, and the stability counter is held at 0.
- Stability counter:
  - Increments (saturating) while the current sample equals the previous sample.
  - Reloads to 0 on any change.
  - A capture fires exactly once per dwell, on the cycle the counter reaches STABLE_CYCLES-1 with a valid position.
- Segment decode (bits[6:0], DP ignored): c0=0, f9=1, a4=2, b0=3, 99=4, 92=5, 82=6, f8=7, 80=8, 90=9, 88=a, 83=b, c6=c, a1=d, 86=e, 8e=f.
  - Any other pattern: frame_err pulses, seen is cleared, state returns to IDLE.
- State machine:
  - IDLE: the first capture stores the slot, sets its seen bit and moves to COLLECT.
  - COLLECT: each capture stores its slot and sets its seen bit. Re-capturing an already-seen position overwrites that slot (latest wins).
  - When a capture makes seen==1111, go to EMIT.
  - EMIT (one cycle):
    - If every slot is <=9: digit = d3*1000 + d2*100 + d1*10 + d0 and digit_valid=1.
    - Otherwise: frame_err=1 and digit is held.
    - In both cases seen is cleared and the next state is IDLE.
- Latency: the capture edge of the 4th slot is edge E. digit and digit_valid (or frame_err) are registered at edge E+1. Total latency from the bus change is 2 (sync) + STABLE_CYCLES + 1 cycles.
- Arithmetic: the multiply-add is 14-bit unsigned. The maximum is 9999, so there is no overflow.
- Timeout: in COLLECT the timeout counter increments every cycle and resets on each capture. At TIMEOUT_CYCLES-1, seen is cleared and the state returns to IDLE silently (no err pulse).
- Simultaneous events: an invalid-pattern error takes priority over frame completion.
- Reset mid-operation: all state is discarded immediately and the outputs return to their reset values.
- digit_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: FND_MON_DP_EN
- Defined:
  - Adds output dp_mask[3:0]. Bit n = ~fndFont[7] as captured for position n.
  - dp_mask updates together with digit on digit_valid. Reset value 0.
- Undefined: no dp_mask port; bit7 is ignored entirely.

Test Plan:
- Sweep for 1234: com 1110/font 99, 1101/b0, 1011/a4, 0111/f9, each held 100 cycles -> digit=1234 with one digit_valid pulse per sweep and frame_err=0.
- Glitch rejection: position 0 held only 10 cycles then blank, followed by the 1234 sweep -> no pulse from the glitch; digit=1234 after the sweep.
- Bad pattern: com 1110/font ff held 100 cycles -> frame_err pulses once; seen is cleared; digit unchanged; no digit_valid.
- Hex digit: positions 0-2 valid, position 3 font 8e -> frame_err pulses once at EMIT; digit keeps the prior value 1234.
- Timeout: positions 0-2 captured, then com=1111 for TIMEOUT_CYCLES, then position 3 alone -> no digit_valid and no frame_err.
- Reset mid-frame: reset asserted after 2 captures -> digit=0, digit_valid=0, frame_err=0 at once. A fresh full sweep of 9999 then gives digit=9999.

Source files
------------

// File: rtl/fnd_scan_monitor_if.sv
// Scan-bus bundle between an FND display driver and fnd_scan_monitor.
// Define FND_MON_DP_EN to add the per-position decimal-point mask.
interface fnd_scan_monitor_if;
    logic [3:0]  fndCom;
    logic [7:0]  fndFont;
    logic [13:0] digit;
    logic        digit_valid;
    logic        frame_err;
`ifdef FND_MON_DP_EN
    logic [3:0]  dp_mask;
`endif

    modport master (
        output fndCom,
        output fndFont,
        input  digit,
        input  digit_valid,
`ifdef FND_MON_DP_EN
        input  dp_mask,
`endif
        input  frame_err
    );

    modport slave (
        input  fndCom,
        input  fndFont,
        output digit,
        output digit_valid,
`ifdef FND_MON_DP_EN
        output dp_mask,
`endif
        output frame_err
    );
endinterface

// File: rtl/fnd_scan_monitor.sv
// Samples a multiplexed 7-segment scan bus and rebuilds the displayed 0..9999 value.
// Optional macro FND_MON_DP_EN adds dp_mask, the decimal points seen per position.
module fnd_scan_monitor #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 400_000
) (
    input  logic               clk,
    input  logic               reset,
    fnd_scan_monitor_if.slave  bus
);

    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_PRE  = STAB_W'(STABLE_CYCLES - 2);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    // Returns {ok, value}; bit 7 (DP) is never part of the glyph.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40: seg_decode = 5'h10;  7'h79: seg_decode = 5'h11;
            7'h24: seg_decode = 5'h12;  7'h30: seg_decode = 5'h13;
            7'h19: seg_decode = 5'h14;  7'h12: seg_decode = 5'h15;
            7'h02: seg_decode = 5'h16;  7'h78: seg_decode = 5'h17;
            7'h00: seg_decode = 5'h18;  7'h10: seg_decode = 5'h19;
            7'h08: seg_decode = 5'h1a;  7'h03: seg_decode = 5'h1b;
            7'h46: seg_decode = 5'h1c;  7'h21: seg_decode = 5'h1d;
            7'h06: seg_decode = 5'h1e;  7'h0e: seg_decode = 5'h1f;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    logic [3:0]        com_s1, com_s2, com_prev;
    logic [7:0]        font_s1, font_s2, font_prev;
    logic [STAB_W-1:0] stab_q;
    logic [TO_W-1:0]   to_q, to_d;
    state_t            state_q, state_d;
    logic [3:0]        seen_q, seen_d;
    logic [3:0]        slot [4];
    logic              pos_vld, same, cap, seg_ok, wr_slot, emit_ok, err_d, all_dec;
    logic [1:0]        pos_idx;
    logic [3:0]        pos_oh, seg_val;
    logic [13:0]       digit_q, frame_value;
    logic              valid_q, err_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            com_s1    <= 4'hf;
            com_s2    <= 4'hf;
            com_prev  <= 4'hf;
            font_s1   <= 8'hff;
            font_s2   <= 8'hff;
            font_prev <= 8'hff;
        end else begin
            com_s1    <= bus.fndCom;
            com_s2    <= com_s1;
            com_prev  <= com_s2;
            font_s1   <= bus.fndFont;
            font_s2   <= font_s1;
            font_prev <= font_s2;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pos_vld = 1'b1;
        pos_idx = 2'd0;
        case (com_s2)
            4'b1110: pos_idx = 2'd0;
            4'b1101: pos_idx = 2'd1;
            4'b1011: pos_idx = 2'd2;
            4'b0111: pos_idx = 2'd3;
            default: pos_vld = 1'b0;
        endcase
    end

    assign pos_oh = 4'b0001 << pos_idx;
    assign same   = (com_s2 == com_prev) && (font_s2 == font_prev);
    // Capture on the edge where the dwell counter reaches its final value.
    assign cap    = pos_vld && same && (stab_q == STAB_PRE);
    assign {seg_ok, seg_val} = seg_decode(font_s2[6:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stab_q <= '0;
        else if (!same || !pos_vld)
            stab_q <= '0;
        else if (stab_q != STAB_LAST)
            stab_q <= stab_q + 1'b1;
    end

    assign all_dec = (slot[0] <= 4'd9) && (slot[1] <= 4'd9) &&
                     (slot[2] <= 4'd9) && (slot[3] <= 4'd9);
    assign frame_value = 14'(slot[3]) * 14'd1000 + 14'(slot[2]) * 14'd100 +
                         14'(slot[1]) * 14'd10   + 14'(slot[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            seen_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        to_d    = '0;
        wr_slot = 1'b0;
        emit_ok = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap && !seg_ok) begin
                    err_d  = 1'b1;
                    seen_d = '0;
                end else if (cap) begin
                    wr_slot = 1'b1;
                    seen_d  = pos_oh;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (cap && !seg_ok) begin
                    err_d   = 1'b1;
                    seen_d  = '0;
                    state_d = IDLE;
                end else if (cap) begin
                    wr_slot = 1'b1;
                    seen_d  = seen_q | pos_oh;
                    if ((seen_q | pos_oh) == 4'hf)
                        state_d = EMIT;
                end else if (to_q == TO_LAST) begin
                    seen_d  = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            EMIT: begin
                emit_ok = all_dec;
                err_d   = !all_dec;
                seen_d  = '0;
                state_d = IDLE;
            end
            default: begin
                seen_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the slot array is reset because a partial frame must never reuse stale digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) slot[i] <= '0;
        end else if (wr_slot) begin
            slot[pos_idx] <= seg_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= emit_ok;
            err_q   <= err_d;
            if (emit_ok)
                digit_q <= frame_value;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_err   = err_q;

`ifdef FND_MON_DP_EN
    logic [3:0] dp_slot, dp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_slot <= '0;
            dp_q    <= '0;
        end else begin
            if (wr_slot)
                dp_slot[pos_idx] <= ~font_s2[7];
            if (emit_ok)
                dp_q <= dp_slot;
        end
    end

    assign bus.dp_mask = dp_q;
`endif

endmodule

// File: tb/tb_fnd_scan_monitor.sv
// Directed bench for fnd_scan_monitor: table of full sweeps plus multi-cycle corner cases.
module tb_fnd_scan_monitor;

    localparam int TIMEOUT = 600;
    localparam int HOLD    = 100;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_valid  = 0;
    int   n_err    = 0;
    int   n_both   = 0;

    fnd_scan_monitor_if bus ();

    fnd_scan_monitor #(
        .STABLE_CYCLES  (16),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.digit_valid) n_valid++;
        if (bus.frame_err)   n_err++;
        if (bus.digit_valid && bus.frame_err) n_both++;
    end

    typedef struct {
        logic [7:0]  f0, f1, f2, f3;
        logic [13:0] exp_digit;
        int          exp_valid;
        int          exp_err;
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic show(input logic [3:0] com, input logic [7:0] font, input int cycles);
        bus.fndCom  = com;
        bus.fndFont = font;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic sweep(input logic [7:0] f0, f1, f2, f3);
        show(4'b1110, f0, HOLD);
        show(4'b1101, f1, HOLD);
        show(4'b1011, f2, HOLD);
        show(4'b0111, f3, HOLD);
        show(4'b1111, 8'hff, 10);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, e0, lat;

        vecs[0] = '{8'h99, 8'hb0, 8'ha4, 8'hf9, 14'd1234, 1, 0, 4'b0000};
        vecs[1] = '{8'h82, 8'hf8, 8'h80, 8'h90, 14'd9876, 1, 0, 4'b0000};
        vecs[2] = '{8'hc0, 8'hc0, 8'hc0, 8'hc0, 14'd0,    1, 0, 4'b0000};
        vecs[3] = '{8'h19, 8'h92, 8'hc0, 8'h92, 14'd5054, 1, 0, 4'b0001};
        vecs[4] = '{8'hc0, 8'hc0, 8'hc0, 8'h8e, 14'd5054, 0, 1, 4'b0001};
        vecs[5] = '{8'ha4, 8'hf9, 8'h79, 8'h99, 14'd4112, 1, 0, 4'b0100};

        reset       = 1'b1;
        bus.fndCom  = 4'hf;
        bus.fndFont = 8'hff;
        repeat (3) @(negedge clk);
        check("reset_digit", 32'(bus.digit), 32'd0);
        check("reset_valid", 32'(bus.digit_valid), 32'd0);
        check("reset_err",   32'(bus.frame_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        show(4'hf, 8'hff, 5);

        for (int i = 0; i < 6; i++) begin
            v0 = n_valid;
            e0 = n_err;
            sweep(vecs[i].f0, vecs[i].f1, vecs[i].f2, vecs[i].f3);
            check($sformatf("vec%0d_digit", i), 32'(bus.digit), 32'(vecs[i].exp_digit));
            check($sformatf("vec%0d_valid_pulses", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_err_pulses", i), 32'(n_err - e0), 32'(vecs[i].exp_err));
`ifdef FND_MON_DP_EN
            check($sformatf("vec%0d_dp_mask", i), 32'(bus.dp_mask), 32'(vecs[i].exp_dp));
`endif
        end

        // Latency from the last position's bus change to the valid strobe.
        show(4'b1110, 8'hf9, HOLD);
        show(4'b1101, 8'ha4, HOLD);
        show(4'b1011, 8'hb0, HOLD);
        bus.fndCom  = 4'b0111;
        bus.fndFont = 8'h99;
        lat = 0;
        for (int n = 1; n <= 50 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (bus.digit_valid) lat = n;
        end
        check("latency_cycles", 32'(lat), 32'd19);
        check("latency_digit",  32'(bus.digit), 32'd4321);
        show(4'b0111, 8'h99, HOLD);
        show(4'b1111, 8'hff, 10);

        // Short dwell must not capture; the following sweep must emit once.
        v0 = n_valid;
        e0 = n_err;
        show(4'b1110, 8'hc0, 10);
        show(4'b1111, 8'hff, 20);
        check("glitch_no_pulse", 32'(n_valid - v0), 32'd0);
        sweep(8'h99, 8'hb0, 8'ha4, 8'hf9);
        check("glitch_digit",  32'(bus.digit), 32'd1234);
        check("glitch_valid",  32'(n_valid - v0), 32'd1);
        check("glitch_err",    32'(n_err - e0), 32'd0);

        // Undecodable glyph.
        v0 = n_valid;
        e0 = n_err;
        show(4'b1110, 8'hff, HOLD);
        show(4'b1111, 8'hff, 10);
        check("bad_err",   32'(n_err - e0), 32'd1);
        check("bad_valid", 32'(n_valid - v0), 32'd0);
        check("bad_digit", 32'(bus.digit), 32'd1234);

        // Partial frame abandoned by the timeout.
        v0 = n_valid;
        e0 = n_err;
        show(4'b1110, 8'h99, HOLD);
        show(4'b1101, 8'hb0, HOLD);
        show(4'b1011, 8'ha4, HOLD);
        show(4'b1111, 8'hff, TIMEOUT);
        show(4'b0111, 8'hf9, HOLD);
        show(4'b1111, 8'hff, 10);
        check("timeout_valid", 32'(n_valid - v0), 32'd0);
        check("timeout_err",   32'(n_err - e0), 32'd0);
        check("timeout_digit", 32'(bus.digit), 32'd1234);

        // Reset in the middle of a frame.
        show(4'b1110, 8'h92, HOLD);
        show(4'b1101, 8'h92, HOLD);
        reset = 1'b1;
        #1;
        check("midreset_digit", 32'(bus.digit), 32'd0);
        check("midreset_valid", 32'(bus.digit_valid), 32'd0);
        check("midreset_err",   32'(bus.frame_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        show(4'b1111, 8'hff, 5);
        v0 = n_valid;
        sweep(8'h90, 8'h90, 8'h90, 8'h90);
        check("after_reset_digit", 32'(bus.digit), 32'd9999);
        check("after_reset_valid", 32'(n_valid - v0), 32'd1);

        check("never_both", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
